// File: rtl/riscv_dmem_ctrl.sv
// Data-memory controller: word RAM behind a valid/ready request port, byte/half/word stores, extended loads, fault flag.
// Latency: accept at edge N -> rsp_valid_o sampled at edge N+2+WAIT_STATES; one access per 3+WAIT_STATES cycles.
// Backpressure: req_ready_o high only in IDLE; the response pulse has no backpressure.
// Optional: define RISCV_DMEM_PERF_EN to add load/store performance counters.
module riscv_dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
`ifdef RISCV_DMEM_PERF_EN
  ,
  output logic [31:0] perf_rd_cnt_o,
  output logic [31:0] perf_wr_cnt_o
`endif
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      wait_q, wait_d;
  logic            we_q, uns_q, err_q;
  logic [AW+1:0]   off_q;
  logic [31:0]     wdata_q;
  logic [1:0]      size_q;

  logic            accept;
  logic [31:0]     req_off;
  logic            req_err;
  logic [AW-1:0]   widx;
  logic [3:0]      lane_en;
  logic [31:0]     wr_word, rd_word, ld_val;
  logic [15:0]     shifted;

  // Contents survive reset; they start at zero only at power-up.
  logic [31:0]     mem_q [DEPTH_WORDS] = '{default: 32'h0};

  assign req_ready_o = (state_q == S_IDLE);
  assign accept      = req_valid_i & req_ready_o;
  assign widx        = off_q[AW+1:2];

  // Fault check on the incoming request; the offset wraps so addresses below BASE_ADDR fault too
  always_comb begin
    req_off = req_addr_i - BASE_ADDR;
    req_err = (req_size_i == 2'b11)
           || ((req_size_i == 2'b01) && req_addr_i[0])
           || ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00))
           || (req_off >= SPAN);
  end

  // State register, request latch and wait counter
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      we_q    <= 1'b0;
      off_q   <= '0;
      wdata_q <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (accept) begin
        we_q    <= req_we_i;
        off_q   <= req_off[AW+1:0];
        wdata_q <= req_wdata_i;
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        err_q   <= req_err;
      end
    end
  end

  // Next-state logic: IDLE -> WAIT (WAIT_STATES cycles) -> COMMIT -> RESP -> IDLE
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            wait_d  = 4'(WAIT_STATES) - 4'd1;
          end else begin
            state_d = S_COMMIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_q == 4'd0) state_d = S_COMMIT;
        else                wait_d  = wait_q - 4'd1;
      end
      S_COMMIT: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Store lane enables with the data replicated so every lane sees its own bytes
  always_comb begin
    lane_en = 4'b0000;
    wr_word = wdata_q;
    case (size_q)
      2'b00: begin
        lane_en = 4'b0001 << off_q[1:0];
        wr_word = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_en = off_q[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata_q[15:0]}};
      end
      2'b10:   lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  // Load path: pick the addressed byte/half and extend it
  always_comb begin
    rd_word = mem_q[widx];
    shifted = 16'(rd_word >> {off_q[1:0], 3'b000});
    case (size_q)
      2'b00:   ld_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   ld_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: ld_val = rd_word;
    endcase
  end

  // RAM write at COMMIT; a reset on that same edge wins and suppresses it
  always_ff @(posedge clock) begin
    if (reset_n && (state_q == S_COMMIT) && we_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem_q[widx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  // Response registers: loaded at COMMIT so they are live only during RESP
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (state_q == S_COMMIT) begin
      rsp_valid_o <= 1'b1;
      rsp_err_o   <= err_q;
      rsp_rdata_o <= (we_q || err_q) ? 32'h0 : ld_val;
    end else begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end
  end

`ifdef RISCV_DMEM_PERF_EN
  // Count successful loads and stores at COMMIT; wrap naturally at 32 bits
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      perf_rd_cnt_o <= '0;
      perf_wr_cnt_o <= '0;
    end else if ((state_q == S_COMMIT) && !err_q) begin
      if (we_q) perf_wr_cnt_o <= perf_wr_cnt_o + 32'd1;
      else      perf_rd_cnt_o <= perf_rd_cnt_o + 32'd1;
    end
  end
`endif

endmodule
